// File: rtl/nonrestoring_divider_pkg.sv
// Shared types and constants for the radix-2 non-restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Iteration counter width; WIDTH is at least 4, so the result is always >= 2.
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Start/ready request bus between the issuing pipeline (master) and the divider (slave).
// The remainder signal exists only when DIV_REMAINDER_EN is defined.
interface nonrestoring_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    // Handshake: start is sampled only while the divider is IDLE. Operands are
    // captured on that edge and may change afterwards. ready is a one-cycle
    // pulse; quotient/exception (and remainder) are valid during it and held
    // until the next result is produced.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic             exception;
    logic             ready;
    logic             busy;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] remainder;
`endif

    modport master (
        output start, dividend, divisor,
        input  quotient, exception, ready, busy
`ifdef DIV_REMAINDER_EN
        , input remainder
`endif
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, exception, ready, busy
`ifdef DIV_REMAINDER_EN
        , output remainder
`endif
    );

endinterface

// File: rtl/nonrestoring_divider_iter_counter.sv
// Iteration counter shared in shape with the multiplier: counts 0..WIDTH-1 while enabled.
module div_iter_counter
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    logic [CW-1:0] count_q, count_d;

    assign last_o  = (count_q == CW'(WIDTH - 1));
    assign count_o = count_q;

    // Wraps to zero after the last iteration so the next operation starts clean.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one quotient bit per cycle (radix-2 non-restoring).
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CW    = cnt_w(WIDTH)
) (
    input  logic                   clk,
    input  logic                   clr,
    nonrestoring_divider_if.slave  bus,
    output div_state_e             dbg_state_o,
    output logic [CW-1:0]          dbg_count_o
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;          // signed partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into quotient bits
    logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic             cnt_en;
    logic             cnt_last;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_step;
    logic [WIDTH:0]   r_fix;

    div_iter_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .clr     (clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .last_o  (cnt_last)
    );

    assign cnt_en = (state_q == RUN);

    // Magnitudes are unsigned WIDTH bits, so negating the most negative value is exact.
    assign dividend_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign divisor_abs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_step  = r_q[WIDTH] ? (r_shift + {1'b0, d_q}) : (r_shift - {1'b0, d_q});
    assign r_fix   = r_q[WIDTH] ? (r_q + {1'b0, d_q}) : r_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        qneg_d  = qneg_q;
        quot_d  = quot_q;
        exc_d   = exc_q;
`ifdef DIV_REMAINDER_EN
        rneg_d  = rneg_q;
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d  = '0;
                        exc_d   = 1'b1;
`ifdef DIV_REMAINDER_EN
                        rem_d   = bus.dividend;
`endif
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = dividend_abs;
                        d_d     = divisor_abs;
                        qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                        rneg_d  = bus.dividend[WIDTH-1];
`endif
                        exc_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d = r_step;
                q_d = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
                if (cnt_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                r_d     = r_fix;
                quot_d  = qneg_q ? -q_q : q_q;
`ifdef DIV_REMAINDER_EN
                rem_d   = rneg_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            qneg_q  <= 1'b0;
            quot_q  <= '0;
            exc_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rneg_q  <= 1'b0;
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            qneg_q  <= qneg_d;
            quot_q  <= quot_d;
            exc_q   <= exc_d;
`ifdef DIV_REMAINDER_EN
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.exception = exc_q;
    assign bus.ready     = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == FIX);
`ifdef DIV_REMAINDER_EN
    assign bus.remainder = rem_q;
`endif

    assign dbg_state_o = state_q;
    assign dbg_count_o = cnt;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed cases, handshake corner cases, random ops.
module tb_nonrestoring_divider;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  div_state_e dbg_state;
  logic [DIV_CNT_W-1:0] dbg_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_e[$];

  nonrestoring_divider_if #(.WIDTH(W)) bus();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain signed arithmetic, truncating division, remainder follows dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e);
    longint sa, sb, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = '0; r = a; e = 1'b1;
    end else begin
      tq = sa / sb;
      tr = sa % sb;
      q = tq[W-1:0]; r = tr[W-1:0]; e = 1'b0;
    end
  endfunction

  // Driver: must be called at a negedge; returns at the negedge after the ready cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke_cyc, input bit poke_done,
                       output int lat, output int busy_cyc, output bit pulse_ok,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    lat = -1; busy_cyc = 0; pulse_ok = 1'b0; q = '0; r = '0; e = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      bus.start = 1'b0;
      if (bus.ready === 1'b1) begin
        lat = c; q = bus.quotient; e = bus.exception;
`ifdef DIV_REMAINDER_EN
        r = bus.remainder;
`endif
        if (poke_done) begin
          bus.start = 1'b1; bus.dividend = 32'h0000_0077; bus.divisor = 32'h0000_0001;
        end
        break;
      end
      if (c == poke_cyc) begin
        bus.start = 1'b1; bus.dividend = 32'd7; bus.divisor = 32'd7;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    pulse_ok = (bus.ready === 1'b0);
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient); end
    checks++; if (bus.exception !== 1'b0) begin errors++; $display("FAIL reset_exception: got %b expected 0", bus.exception); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    checks++; if (dbg_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dbg_count); end
`ifdef DIV_REMAINDER_EN
    checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder); end
`endif
    bus.start = 1'b0;
    clr = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[10] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000,
                            32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb_[10] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                             32'd1, 32'd100, 32'd2, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] tq[10] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000,
                            32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd1};
    logic [W-1:0] tr[10] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd0,
                            32'd0, 32'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0};
    int lat, bc; bit pok; logic [W-1:0] q, r; logic e;
    for (int i = 0; i < 10; i++) begin
      do_op(ta[i], tb_[i], -1, 1'b0, lat, bc, pok, q, r, e);
      checks++; if (q !== tq[i]) begin errors++; $display("FAIL directed_quotient[%0d]: got %h expected %h", i, q, tq[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL directed_exception[%0d]: got %b expected 0", i, e); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      checks++; if (bc !== LAT - 1) begin errors++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected %0d", i, bc, LAT - 1); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL directed_ready_pulse[%0d]: ready still high after pulse", i); end
`ifdef DIV_REMAINDER_EN
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL directed_remainder[%0d]: got %h expected %h", i, r, tr[i]); end
`endif
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] ta[2] = '{32'd5, 32'hFFFF_FFFD};
    int lat, bc; bit pok; logic [W-1:0] q, r; logic e;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], 32'd0, -1, 1'b0, lat, bc, pok, q, r, e);
      checks++; if (q !== '0) begin errors++; $display("FAIL div0_quotient[%0d]: got %h expected 0", i, q); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL div0_exception[%0d]: got %b expected 1", i, e); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL div0_busy_cycles[%0d]: got %0d expected 0", i, bc); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL div0_ready_pulse[%0d]: ready still high after pulse", i); end
`ifdef DIV_REMAINDER_EN
      checks++; if (r !== ta[i]) begin errors++; $display("FAIL div0_remainder[%0d]: got %h expected %h", i, r, ta[i]); end
`endif
    end
  endtask

  task automatic test_start_ignored();
    int lat, bc; bit pok; logic [W-1:0] q, r; logic e;
    do_op(32'd1000, 32'd10, 10, 1'b0, lat, bc, pok, q, r, e);
    checks++; if (q !== 32'd100) begin errors++; $display("FAIL ignored_quotient: got %h expected %h", q, 32'd100); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", lat, LAT); end
`ifdef DIV_REMAINDER_EN
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL ignored_remainder: got %h expected 0", r); end
`endif
  endtask

  task automatic test_abort();
    int lat, bc, seen; bit pok; logic [W-1:0] q, r; logic e;
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL abort_quotient: got %h expected 0", bus.quotient); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", bus.ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d expected IDLE", dbg_state); end
    checks++; if (dbg_count !== '0) begin errors++; $display("FAIL abort_count: got %0d expected 0", dbg_count); end
`ifdef DIV_REMAINDER_EN
    checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL abort_remainder: got %h expected 0", bus.remainder); end
`endif
    @(negedge clk);
    clr = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", seen); end
    do_op(32'd9, 32'd3, -1, 1'b0, lat, bc, pok, q, r, e);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL abort_next_quotient: got %h expected 3", q); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT); end
  endtask

  // Random operand mix, scoreboarded through expected queues.
  task automatic run_random(input int n, input bit chained, input string tag);
    int lat, bc; bit pok; logic [W-1:0] q, r, a, b, eq, er; logic e, ee;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      if ($urandom_range(0, 1) == 1) a = -a;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      ref_div(a, b, eq, er, ee);
      exp_q.push_back(eq); exp_r.push_back(er); exp_e.push_back(ee);
      do_op(a, b, -1, chained, lat, bc, pok, q, r, e);
      eq = exp_q.pop_front(); er = exp_r.pop_front(); ee = exp_e.pop_front();
      checks++; if (q !== eq) begin errors++; $display("FAIL %s_quotient[%0d] %h/%h: got %h expected %h", tag, i, a, b, q, eq); end
      checks++; if (e !== ee) begin errors++; $display("FAIL %s_exception[%0d]: got %b expected %b", tag, i, e, ee); end
      checks++; if (lat !== (ee ? 1 : LAT)) begin errors++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lat, ee ? 1 : LAT); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL %s_ready_pulse[%0d]: ready still high after pulse", tag, i); end
`ifdef DIV_REMAINDER_EN
      checks++; if (r !== er) begin errors++; $display("FAIL %s_remainder[%0d]: got %h expected %h", tag, i, r, er); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    run_random(8, 1'b1, "b2b");
  endtask

  task automatic test_random();
    run_random(40, 1'b0, "random");
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
- Sequential signed integer divider; the division counterpart of the multdiv Booth multiplier.
- Radix-2 non-restoring algorithm, one quotient bit per cycle, driven by an internal iteration counter.
- Sits beside the multiplier in the multdiv unit; the ALU/pipeline issues one operation at a time with a start/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 4).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset; synchronous, active-low (clr=0 at a rising edge resets).
- start  in  1  operation request; sampled only in IDLE.
- dividend  in  WIDTH  signed two's-complement, latched on accepted start.
- divisor  in  WIDTH  signed two's-complement, latched on accepted start.
- quotient  out  WIDTH  signed result; valid while ready=1, held until next accepted start.
- exception  out  1  divide-by-zero flag; valid with ready.
- ready  out  1  one-cycle pulse marking result valid.
- busy  out  1  high from the cycle after an accepted start until ready pulses.

Behaviour:
- Reset (clr=0): state=IDLE, quotient=0, exception=0, ready=0, busy=0, counter=0. Reset mid-operation aborts immediately; no ready pulse follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1, divisor!=0: latch |dividend|, |divisor| and result signs (quotient sign = sign XOR; remainder sign = dividend sign); clear partial remainder; go to RUN.
  - start=1, divisor==0: go to DONE with exception=1, quotient=0.
- RUN: WIDTH cycles; counter 0..WIDTH-1.
  - Each cycle: shift {R,Q} left 1.
  - R>=0: R=R-D; else R=R+D.
  - Q[0] = ~R_new[MSB].
  - Counter reaching WIDTH-1 -> FIX.
- FIX:
  - If R<0, R=R+D.
  - Apply signs to quotient/remainder (two's-complement negate).
  - Go to DONE.
- DONE: ready=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge 0 -> ready high in cycle WIDTH+2 (34 for WIDTH=32); divide-by-zero -> ready in cycle 1.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign.
- Width rules:
  - Partial remainder is WIDTH+1 bits.
  - Magnitudes are WIDTH bits unsigned, so |-2^(WIDTH-1)| is representable.
  - -2^(WIDTH-1) / -1 wraps to quotient 0x80000000 (WIDTH=32); exception=0.
- start while busy/FIX/DONE: ignored; inputs not re-latched.
- Inputs may change freely after the accepted start edge.
- Simultaneous clr=0 and start=1: reset wins.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined: adds output port remainder [WIDTH-1:0], signed, valid with ready, held like quotient. Reset value 0. Divide-by-zero gives remainder = dividend.
- Undefined: no remainder port. Remainder register is still used internally by the algorithm; only the sign-fix logic for the remainder output is removed.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, RUN, FIX, DONE}.
  - DIV_WIDTH default 32.
  - Counter width constant $clog2(WIDTH).
- Sub-module div_iter_counter:
  - Synchronous active-low clear plus an enable.
  - Outputs count and a last flag (count==WIDTH-1).
  - Mirrors the multiplier's iteration counter.
- Datapath (shift/add-subtract) and FSM stay in nonrestoring_divider.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2 (if DIV_REMAINDER_EN), exception=0; ready exactly at cycle 34, single-cycle pulse.
- -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2; 100 / -7 -> quotient=-14, remainder=2; -100 / -7 -> quotient=14, remainder=-2.
- 5 / 0 -> ready at cycle 1, exception=1, quotient=0, remainder=5; busy stays 0 for the whole sequence.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, exception=0; 0x80000000 / 1 -> quotient=0x80000000, remainder=0.
- Start 1000/10, pulse start with 7/7 at cycle 10 -> ignored; result quotient=100 at cycle 34; next start accepted in the cycle after ready.
- Start 1000/10, drive clr=0 at cycle 15 -> all outputs 0 next cycle, no ready pulse; new start 9/3 -> quotient=3 after 34 cycles.
